// File: rtl/lcd_cmd_pkg.sv
// Shared opcode map, scheduler state encoding and opcode classification helpers
// for the LCD command scheduler.
package lcd_cmd_pkg;

  localparam logic [3:0] CMD_WRITE      = 4'd0;
  localparam logic [3:0] CMD_SHIFT_UP   = 4'd1;
  localparam logic [3:0] CMD_SHIFT_DOWN = 4'd2;
  localparam logic [3:0] CMD_SHIFT_LEFT = 4'd3;
  localparam logic [3:0] CMD_SHIFT_RGT  = 4'd4;
  localparam logic [3:0] CMD_MAX        = 4'd5;
  localparam logic [3:0] CMD_MIN        = 4'd6;
  localparam logic [3:0] CMD_AVERAGE    = 4'd7;
  localparam logic [3:0] CMD_CCW        = 4'd8;
  localparam logic [3:0] CMD_CW         = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X   = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y   = 4'd11;
  localparam logic [3:0] CMD_LAST_LEGAL = 4'd11;

  typedef enum logic [2:0] {
    StLoadWait,
    StIssue,
    StGap,
    StWaitDone,
    StDone
  } sched_state_e;

  function automatic logic is_legal(logic [3:0] op);
    return op <= CMD_LAST_LEGAL;
  endfunction

  function automatic logic is_write(logic [3:0] op);
    return op == CMD_WRITE;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO of 4-bit opcodes; full/empty from wrap-bit pointers.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [3:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [3:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [3:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Two-source round-robin command scheduler with Write barrier, issue gap and
// frame completion tracking in front of the LCD image controller.
module lcd_cmd_sched
  import lcd_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a_valid,
  input  logic [3:0]       req_a_cmd,
  output logic             req_a_ready,
  input  logic             req_b_valid,
  input  logic [3:0]       req_b_cmd,
  output logic             req_b_ready,
  input  logic             lcd_busy,
  input  logic             lcd_done,
  output logic [3:0]       lcd_cmd,
  output logic             lcd_cmd_valid,
  output logic             frame_done,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapInit = GapW'(GAP_CYCLES - 1);

  sched_state_e     state_q, state_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             rr_q, rr_d;  // 0: A has priority, 1: B has priority
  logic [3:0]       cmd_q, cmd_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic       full_a, empty_a, full_b, empty_b;
  logic [3:0] head_a, head_b;
  logic       push_a, push_b, pop_a, pop_b;
  logic       accept, in_issue;
  logic       drop_a, drop_b, elig_a, elig_b;
  logic       grant, gnt_a, gnt_b;
  logic [3:0] gnt_cmd;

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk    (clk),
    .reset  (reset),
    .push_i (push_a),
    .data_i (req_a_cmd),
    .pop_i  (pop_a),
    .full_o (full_a),
    .empty_o(empty_a),
    .head_o (head_a)
  );

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk    (clk),
    .reset  (reset),
    .push_i (push_b),
    .data_i (req_b_cmd),
    .pop_i  (pop_b),
    .full_o (full_b),
    .empty_o(empty_b),
    .head_o (head_b)
  );

  assign push_a = req_a_valid && req_a_ready;
  assign push_b = req_b_valid && req_b_ready;

  // Arbitration: illegal heads are flushed (A first) without using the grant slot.
  always_comb begin
    in_issue = (state_q == StIssue);
    drop_a   = in_issue && !empty_a && !is_legal(head_a);
    drop_b   = in_issue && !drop_a && !empty_b && !is_legal(head_b);
    elig_a   = !empty_a && is_legal(head_a) &&
               (!is_write(head_a) || empty_b || is_write(head_b));
    elig_b   = !empty_b && is_legal(head_b) &&
               (!is_write(head_b) || empty_a || is_write(head_a));
    grant    = in_issue && !lcd_busy && (elig_a || elig_b);
    gnt_a    = grant && elig_a && (!rr_q || !elig_b);
    gnt_b    = grant && !gnt_a;
    gnt_cmd  = gnt_a ? head_a : head_b;
    pop_a    = drop_a || gnt_a;
    pop_b    = drop_b || gnt_b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StLoadWait;
      gap_q   <= '0;
      rr_q    <= 1'b0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      issue_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      issue_q <= issue_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    rr_d    = rr_q;
    cmd_d   = cmd_q;
    valid_d = grant;
    issue_d = issue_q;
    drop_d  = drop_q;
    unique case (state_q)
      StLoadWait: if (!lcd_busy) state_d = StIssue;
      StIssue: begin
        if (grant) begin
          state_d = is_write(gnt_cmd) ? StWaitDone : StGap;
          gap_d   = GapInit;
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIssue;
        else             gap_d   = gap_q - GapW'(1);
      end
      StWaitDone: if (lcd_done) state_d = StDone;
      StDone:     state_d = StDone;
      default:    state_d = StLoadWait;
    endcase
    if (grant) begin
      cmd_d   = gnt_cmd;
      rr_d    = gnt_a;
      issue_d = issue_q + CNT_W'(1);
    end
    if ((drop_a || drop_b) && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
  end

  always_comb begin
    accept        = (state_q == StLoadWait) || (state_q == StIssue) || (state_q == StGap);
    req_a_ready   = accept && !full_a;
    req_b_ready   = accept && !full_b;
    frame_done    = (state_q == StDone);
    lcd_cmd       = cmd_q;
    lcd_cmd_valid = valid_q;
    issue_cnt     = issue_q;
    drop_cnt      = drop_q;
  end

endmodule

// File: doc/lcd_cmd_sched.md
Name: lcd_cmd_sched

Overview:
Command scheduler in front of the LCD image controller. Two independent command sources (A: host, B: scripted playback) each queue 4-bit opcodes into a private FIFO. The scheduler waits for the controller's image load to finish, then round-robin arbitrates and issues one-cycle cmd_valid pulses while the controller is not busy. It enforces a Write barrier and reports frame completion.

Parameters:
FIFO_DEPTH, 4, entries per requester FIFO (power of two, >=2)
GAP_CYCLES, 1, idle cycles forced between consecutive issued commands (>=1)
CNT_W, 8, width of issue and drop counters

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req_a_valid  in  1  requester A command valid
req_a_cmd  in  4  requester A opcode
req_a_ready  out  1  requester A FIFO can accept
req_b_valid  in  1  requester B command valid
req_b_cmd  in  4  requester B opcode
req_b_ready  out  1  requester B FIFO can accept
lcd_busy  in  1  controller busy (high during image load/output)
lcd_done  in  1  controller finished image output
lcd_cmd  out  4  opcode to controller
lcd_cmd_valid  out  1  one-cycle issue strobe
frame_done  out  1  high from Write completion until reset
issue_cnt  out  CNT_W  commands issued, wraps
drop_cnt  out  CNT_W  illegal opcodes dropped, saturates at all-ones

Behaviour:
- Reset (asynchronous, reset==0): FIFOs empty, state LOAD_WAIT, rr_ptr=A. Outputs: lcd_cmd=0, lcd_cmd_valid=0, frame_done=0, issue_cnt=0, drop_cnt=0. req_*_ready=1, since FIFOs are empty and the state accepts pushes. Reset mid-operation discards all queued commands.
- Opcodes: 0 Write; 1-4 Shift Up/Down/Left/Right; 5 Max; 6 Min; 7 Average; 8 CCW; 9 CW; 10 MirrorX; 11 MirrorY; 12-15 illegal.
- Push: an entry is written when valid && ready. ready = !full && state in {LOAD_WAIT, ISSUE, GAP}. A full FIFO does not accept a push in the same cycle as a pop (ready depends on full only).
- States:
  LOAD_WAIT: no issue. Go to ISSUE on the first cycle lcd_busy==0 is sampled.
  ISSUE: each cycle, evaluate the FIFO heads.
    Illegal head opcode: popped without issue; drop_cnt increments and saturates. At most one drop per cycle, A first; drops do not consume arbitration.
    Eligible head: a non-Write head is eligible. A Write head is eligible only if the other FIFO is empty or its head is also Write (Write barrier).
    If lcd_busy==0 and at least one head is eligible, grant: rr_ptr's side when eligible, otherwise the other side. Then pop, register lcd_cmd=head, lcd_cmd_valid=1 on the next cycle, issue_cnt+1, rr_ptr toggles to the non-granted side.
    If the granted opcode is Write, go to WAIT_DONE; otherwise go to GAP.
  GAP: lcd_cmd_valid=0 for GAP_CYCLES cycles (down-counter), then ISSUE. lcd_cmd holds its last value.
  WAIT_DONE: no issue, ready=0. On lcd_done==1, set frame_done=1 and go to DONE.
  DONE: terminal until reset. frame_done=1, ready=0, leftover FIFO entries retained but never issued.
- Latency: command pushed into an empty FIFO in ISSUE with lcd_busy low -> lcd_cmd_valid 2 cycles after the push edge (FIFO write, then grant register).
- lcd_cmd_valid is never high on consecutive cycles. It is never asserted in a cycle following a sample of lcd_busy==1.
- Both FIFOs empty in ISSUE: remain in ISSUE, outputs idle.
- Counters wrap at 2^CNT_W (issue_cnt); drop_cnt saturates.

Decomposition:
- Package lcd_cmd_pkg: opcode constants (CMD_WRITE..CMD_MIRROR_Y, CMD_LAST_LEGAL=11), state encoding (LOAD_WAIT, ISSUE, GAP, WAIT_DONE, DONE), is_legal/is_write helpers.
- Sub-module cmd_fifo: synchronous FIFO, parameter DEPTH, width 4, ports push/pop/full/empty/head. Same async active-low reset; instantiated twice.
- Arbiter, barrier logic, FSM and counters live in lcd_cmd_sched.

Test Plan:
- Reset release with lcd_busy=1 for 70 cycles and A pushing 1,4 -> no lcd_cmd_valid until lcd_busy=0; then cmd 1, gap, cmd 4; issue_cnt=2.
- A queues 5,6 and B queues 7,9 together -> issue order 5,7,6,9 (round-robin starting A), each pulse separated by 1 idle cycle.
- A queues 0 (Write) while B holds 3,3 -> B's 3,3 issued first, then 0; state WAIT_DONE; both ready=0; lcd_done pulse -> frame_done=1 and stays 1.
- B pushes 13, 2 -> 13 dropped (drop_cnt=1, no strobe), 2 issued; 255 illegal pushes -> drop_cnt stays 255.
- A pushes 5 commands with lcd_busy held 1 after load -> ready falls after 4th push; lcd_busy=0 -> all 4 issued in FIFO order.
- Assert reset mid-GAP with queued entries -> all outputs at reset values immediately; no stale command issued after release.
